// File: rtl/amp_ram_pkg.sv
// rtl/amp_ram_pkg.sv - shared requester indices, state type and helpers for the amplitude RAM arbiter
package amp_ram_pkg;

  localparam int STAB    = 0;
  localparam int AMP2    = 1;
  localparam int NONSTAB = 2;
  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} arb_state_t;

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    if (oh[NONSTAB])   return 2'd2;
    else if (oh[AMP2]) return 2'd1;
    else               return 2'd0;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational round-robin winner among three requesters, one-hot result
module rr_pick3
  import amp_ram_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_ptr,
  output logic [NUM_REQ-1:0] pick
);

  // Search starts just after the last owner, so the last owner is always lowest priority.
  always_comb begin
    pick = '0;
    case (last_ptr)
      2'd0: begin
        if (req[AMP2])         pick[AMP2]    = 1'b1;
        else if (req[NONSTAB]) pick[NONSTAB] = 1'b1;
        else if (req[STAB])    pick[STAB]    = 1'b1;
      end
      2'd1: begin
        if (req[NONSTAB])      pick[NONSTAB] = 1'b1;
        else if (req[STAB])    pick[STAB]    = 1'b1;
        else if (req[AMP2])    pick[AMP2]    = 1'b1;
      end
      default: begin
        if (req[STAB])         pick[STAB]    = 1'b1;
        else if (req[AMP2])    pick[AMP2]    = 1'b1;
        else if (req[NONSTAB]) pick[NONSTAB] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ram_amplitude_arbiter.sv
// rtl/ram_amplitude_arbiter.sv - burst-locked round-robin owner of the single-port amplitude RAM
module ram_amplitude_arbiter
  import amp_ram_pkg::*;
#(
  parameter int num_qubit    = 4,
  parameter int amp_width    = 64,
  parameter int drain_cycles = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             release_pulse,
  input  logic [NUM_REQ-1:0]             rd_en_i,
  input  logic [NUM_REQ*num_qubit-1:0]   rd_addr_i,
  input  logic [NUM_REQ-1:0]             wr_en_i,
  input  logic [NUM_REQ*num_qubit-1:0]   wr_addr_i,
  input  logic [NUM_REQ*amp_width-1:0]   wr_data_i,
  output logic                           ram_rd_en,
  output logic                           ram_wr_en,
  output logic [num_qubit-1:0]           ram_rd_addr,
  output logic [num_qubit-1:0]           ram_wr_addr,
  output logic [amp_width-1:0]           ram_wr_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [NUM_REQ-1:0]             ram_amplitude_busy,
  output logic                           access_err
);

  localparam int CW = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] grant_n, pick;
  logic [1:0]         last_ptr, last_ptr_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               err_now;

  rr_pick3 u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .pick     (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_ptr   <= 2'd2;
      cnt        <= '0;
      rd_valid   <= '0;
      access_err <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_ptr   <= last_ptr_n;
      cnt        <= cnt_n;
      rd_valid   <= ram_rd_en ? grant : '0;
      access_err <= access_err | err_now;
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    last_ptr_n = last_ptr;
    cnt_n      = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n    = OWN;
          grant_n    = pick;
          last_ptr_n = onehot_idx(pick);
        end
      end
      OWN: begin
        if (|(release_pulse & grant)) begin
          state_n = DRAIN;
          cnt_n   = CW'(drain_cycles - 1);
        end
      end
      default: begin
        // Drain ends by handing straight to the next winner when one is waiting.
        if (cnt == '0) begin
          if (|req) begin
            state_n    = OWN;
            grant_n    = pick;
            last_ptr_n = onehot_idx(pick);
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && state == OWN && rd_en_i[i]) begin
        ram_rd_en   = 1'b1;
        ram_rd_addr = rd_addr_i[i*num_qubit +: num_qubit];
      end
      if (grant[i] && state != IDLE && wr_en_i[i]) begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = wr_addr_i[i*num_qubit +: num_qubit];
        ram_wr_data = wr_data_i[i*amp_width +: amp_width];
      end
    end
  end

  always_comb begin
    err_now = (|((rd_en_i | wr_en_i) & ~grant))
            | ((state == DRAIN) & (|rd_en_i))
            | ((release_pulse & (release_pulse - 3'd1)) != '0);
    case (state)
      IDLE:    ram_amplitude_busy = '0;
      OWN:     ram_amplitude_busy = ~grant;
      default: ram_amplitude_busy = '1;
    endcase
  end

endmodule

// File: doc/ram_amplitude_arbiter.md
# ram_amplitude_arbiter

Arbitrates single-port access to the amplitude RAM among three requesters: the stabilizer alpha read/modify/write pipeline, the Hadamard amplitude2 determination unit, and the nonstabilizer (Toffoli) amplitude unit. Each requester gets burst-locked ownership, granted round-robin. After release, a drain window lets lagging pipeline writes land. The arbiter drives the per-requester `ram_amplitude_busy` qualifiers that the stabilizer and nonstabilizer controllers already wait on.

## Interface
- `num_qubit`, 4, RAM address width; depth is 2**num_qubit.
- `amp_width`, 64, amplitude word width (real and imaginary halves).
- `drain_cycles`, 4, cycles after release during which the previous owner's writes still pass; must cover read-to-write pipeline lag.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `req` input 3: level request; bit 0 stabilizer, 1 amplitude2, 2 nonstabilizer. Held until grant, dropped after release.
- `release` input 3: one-cycle pulse from the owner, coincident with or after its last read.
- `rd_en_i` input 3: per-requester read enable.
- `rd_addr_i` input 3×num_qubit: per-requester read address.
- `wr_en_i` input 3: per-requester write enable.
- `wr_addr_i` input 3×num_qubit: per-requester write address.
- `wr_data_i` input 3×amp_width: per-requester write data.
- `ram_rd_en`, `ram_wr_en` output 1: enables to the RAM.
- `ram_rd_addr`, `ram_wr_addr` output num_qubit: addresses to the RAM.
- `ram_wr_data` output amp_width: write data to the RAM.
- `grant` output 3: registered one-hot owner; all zero when idle.
- `rd_valid` output 3: one-hot; RAM read data on the shared bus is valid for that requester this cycle.
- `ram_amplitude_busy` output 3: per-requester "RAM not yours".
- `access_err` output 1: sticky flag for an illegal access.

## Operation
- State machine:
  - IDLE: no owner.
  - OWN: a one-hot `grant` is held.
  - DRAIN: a down-counter runs from drain_cycles-1.
- IDLE: if any `req` is set, pick the winner round-robin, starting at the bit after `last_ptr`. Register `grant`, update `last_ptr`, go to OWN.
- OWN: the owner's rd/wr ports are muxed to the RAM. `release[owner]` moves to DRAIN. A release on a non-owner bit is ignored.
- DRAIN: only the previous owner's writes pass. Reads are blocked. When the count reaches 0, clear `grant`.
  - If any `req` is set, arbitrate in that same cycle and enter OWN directly.
  - Otherwise go to IDLE.
- Eligibility: the previous owner may win again, but at lowest priority.
- `ram_amplitude_busy[i]` is 1 when state is not IDLE and not (state is OWN and `grant[i]`). In IDLE all bits are 0.
- `access_err` is set on any of these, and cleared only by reset:
  - `rd_en_i` or `wr_en_i` from a non-owner;
  - `rd_en_i` during DRAIN;
  - `release` on more than one bit in a cycle.
- Blocked accesses never reach the RAM.
- RAM outputs are combinational muxes, gated by `grant` and state. They are all zero when there is no legal access.

## Timing
- `req` sampled in IDLE at cycle t: `grant` is high at t+1, and the owner may access at t+1.
- Read latency is one cycle. `rd_valid[owner]` is the registered `ram_rd_en` tagged with the owner index.
- `release` at cycle r:
  - DRAIN covers r+1 through r+drain_cycles.
  - `grant` drops, or moves to the next owner, at r+drain_cycles+1.
- `release` and a new `rd_en` from the owner in the same cycle: the read passes. It is the last legal read.
- Back-to-back bursts: minimum gap is drain_cycles+1 cycles from release to the next owner's first access.
- Reset, including mid-burst:
  - state IDLE, `grant` 0, `rd_valid` 0, `access_err` 0, busy 0;
  - all RAM outputs 0;
  - `last_ptr` set to 2, so requester 0 has first priority.

## Structure
- Shared package `amp_ram_pkg`:
  - requester index constants STAB=0, AMP2=1, NONSTAB=2;
  - NUM_REQ=3;
  - state enum {IDLE, OWN, DRAIN}.
- One sub-module, `rr_pick3`: combinational round-robin winner from `req` and `last_ptr`, with a one-hot output. Everything else stays in the top module.

## Test plan
- Single request: after reset, `req`=001 at t. Expect `grant`=001 at t+1 and busy=110. A 16-read burst gives `rd_valid[0]` 16 times, each one cycle after its read. `release` at r gives `grant`=000 at r+5.
- Contention: `req`=111 at t. Grant order is 001, then 010, then 100, each starting drain_cycles+1 cycles after the prior release.
- Drain writes: the owner writes 3 cycles after `release`. Expect `ram_wr_en`=1 with the owner's data and no error. A read in DRAIN leaves `ram_rd_en`=0 and sets `access_err`=1.
- Intruder: requester 2 writes address 5 while 0 owns. Expect `ram_wr_en`=0 and `access_err`=1 (sticky).
- Reset mid-burst: drive `rst`=0 during OWN. Expect `grant`, RAM outputs, busy and `rd_valid` at 0 asynchronously. After `rst`=1 with `req`=101, requester 0 wins first.
